// File: rtl/calendar_pkg.sv
// Shared types and constants for the calendar date counter.
// Pure declarations: no logic and no latency.
// No flow control lives here.
package calendar_pkg;

    localparam int MONTHS  = 12;
    localparam int MAX_DAY = 31;

    typedef logic [3:0] month_t;
    typedef logic [5:0] day_t;
    typedef logic [4:0] mlen_t;

    // Non-leap-year month lengths, January first.
    localparam mlen_t MONTH_LEN [MONTHS] = '{
        5'd31, 5'd28, 5'd31, 5'd30, 5'd31, 5'd30,
        5'd31, 5'd31, 5'd30, 5'd31, 5'd30, 5'd31
    };

    typedef enum logic {
        RUN   = 1'b0,
        CHECK = 1'b1
    } state_t;

    // True for month numbers 1..12.
    function automatic logic month_in_range(input month_t m);
        return (m >= 4'd1) && (m <= 4'(MONTHS));
    endfunction

endpackage

// File: rtl/month_len_lut.sv
// Month-length lookup: month number to days in that month (non-leap year).
// Purely combinational, zero cycles.
// No flow control; months outside 1..12 return 0 so callers can flag them.
module month_len_lut
    import calendar_pkg::*;
(
    input  month_t month,
    output mlen_t  len
);

    // Table lookup guarded by the range check; an illegal month reads as length 0.
    always_comb begin
        len = '0;
        if (month_in_range(month)) begin
            len = MONTH_LEN[month - 4'd1];
        end
    end

endmodule

// File: rtl/calendar_date_counter.sv
// Day/month/year register advanced by tick, reloadable through a checked load handshake.
// Tick: one cycle. Load: accepted at edge N, validated and committed at edge N+1.
// loadReady drops for the single CHECK cycle; ticks arriving then are held as one pending advance.
module calendar_date_counter
    import calendar_pkg::*;
#(
    parameter int YEAR_W     = 12,
    parameter int RESET_YEAR = 2024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              loadValid,
    input  logic [5:0]        loadDay,
    input  logic [3:0]        loadMonth,
    input  logic [YEAR_W-1:0] loadYear,
    output logic              loadReady,
    output logic [5:0]        dayOfMonth,
    output logic [3:0]        month,
    output logic [YEAR_W-1:0] year,
    output logic              newYear,
    output logic              loadDone,
    output logic              loadErr
);

    localparam logic [YEAR_W-1:0] YEAR_RST = YEAR_W'(RESET_YEAR);
    localparam logic [YEAR_W-1:0] YEAR_ONE = YEAR_W'(1);

    state_t            state;
    state_t            state_next;

    day_t              cand_day;
    month_t            cand_month;
    logic [YEAR_W-1:0] cand_year;

    logic              pending;
    logic              pending_next;

    // FSM decisions for the current cycle.
    logic              accept;
    logic              advance;
    logic              commit;
    logic              reject;

    // Month lengths for the live date and for the candidate under check.
    mlen_t             cur_len;
    mlen_t             cand_len;
    logic              cand_legal;

    // Date one day ahead of the current one.
    day_t              day_adv;
    month_t            month_adv;
    logic [YEAR_W-1:0] year_adv;
    logic              year_roll;

    month_len_lut u_cur_len (
        .month (month),
        .len   (cur_len)
    );

    month_len_lut u_cand_len (
        .month (cand_month),
        .len   (cand_len)
    );

    // Ready depends only on state so there is no input-to-output path.
    assign loadReady = (state == RUN);

    // A zero length already encodes an out-of-range month.
    assign cand_legal = (cand_len != 5'd0)
                     && (cand_day != 6'd0)
                     && (cand_day <= {1'b0, cand_len});

    // Next-day arithmetic; the live date is always legal so cur_len is never 0 here.
    always_comb begin
        day_adv   = dayOfMonth + 6'd1;
        month_adv = month;
        year_adv  = year;
        year_roll = 1'b0;
        if (dayOfMonth >= {1'b0, cur_len}) begin
            day_adv = 6'd1;
            if (month == 4'(MONTHS)) begin
                month_adv = 4'd1;
                year_adv  = year + YEAR_ONE;
                year_roll = 1'b1;
            end else begin
                month_adv = month + 4'd1;
            end
        end
    end

    // Next-state and control: a load wins over a tick in RUN, and the tick is parked as pending.
    always_comb begin
        state_next   = state;
        pending_next = pending;
        accept       = 1'b0;
        advance      = 1'b0;
        commit       = 1'b0;
        reject       = 1'b0;
        case (state)
            RUN: begin
                if (loadValid) begin
                    accept       = 1'b1;
                    state_next   = CHECK;
                    pending_next = pending | tick;
                end else if (tick || pending) begin
                    // A fresh tick coinciding with a pending one collapses into a single advance.
                    advance      = 1'b1;
                    pending_next = 1'b0;
                end
            end
            CHECK: begin
                state_next   = RUN;
                commit       = cand_legal;
                reject       = ~cand_legal;
                pending_next = pending | tick;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Pending-tick flag; reset discards any tick parked during CHECK.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
        end else begin
            pending <= pending_next;
        end
    end

    // Candidate date captured at handshake and held through CHECK.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand_day   <= '0;
            cand_month <= '0;
            cand_year  <= '0;
        end else if (accept) begin
            cand_day   <= loadDay;
            cand_month <= loadMonth;
            cand_year  <= loadYear;
        end
    end

    // Live date: commit and advance are mutually exclusive by state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dayOfMonth <= 6'd1;
            month      <= 4'd1;
            year       <= YEAR_RST;
        end else if (commit) begin
            dayOfMonth <= cand_day;
            month      <= cand_month;
            year       <= cand_year;
        end else if (advance) begin
            dayOfMonth <= day_adv;
            month      <= month_adv;
            year       <= year_adv;
        end
    end

    // Single-cycle status pulses, registered alongside the date they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            newYear  <= 1'b0;
            loadDone <= 1'b0;
            loadErr  <= 1'b0;
        end else begin
            newYear  <= advance & year_roll;
            loadDone <= commit;
            loadErr  <= reject;
        end
    end

endmodule

// File: tb/tb_calendar_date_counter.sv
// Self-checking bench: directed scenarios then random ticks/loads against a day-of-year model.
// Model tracks the date as an ordinal 0..364 plus a year and converts back to day/month.
// Outputs are compared every cycle, 1 time unit after the rising edge.
module tb_calendar_date_counter;

    localparam int YEAR_W     = 12;
    localparam int RESET_YEAR = 2024;
    localparam int YEAR_MOD   = 1 << YEAR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              tick;
    logic              load_valid;
    logic [5:0]        load_day;
    logic [3:0]        load_month;
    logic [YEAR_W-1:0] load_year;
    logic              load_ready;
    logic [5:0]        day_of_month;
    logic [3:0]        month;
    logic [YEAR_W-1:0] year;
    logic              new_year;
    logic              load_done;
    logic              load_err;

    int checks = 0;
    int errors = 0;

    calendar_date_counter #(
        .YEAR_W     (YEAR_W),
        .RESET_YEAR (RESET_YEAR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .loadValid  (load_valid),
        .loadDay    (load_day),
        .loadMonth  (load_month),
        .loadYear   (load_year),
        .loadReady  (load_ready),
        .dayOfMonth (day_of_month),
        .month      (month),
        .year       (year),
        .newYear    (new_year),
        .loadDone   (load_done),
        .loadErr    (load_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int mlen [12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};

    int m_doy, m_year;           // ordinal day 0..364 and year
    bit m_busy, m_pend;          // load under validation, parked tick
    bit m_ny, m_done, m_err;     // expected pulses
    int c_d, c_m, c_y;           // load under validation

    function automatic bit legal(input int d, input int m);
        if (m < 1 || m > 12) return 1'b0;
        return (d >= 1) && (d <= mlen[m-1]);
    endfunction

    function automatic int doy_of(input int d, input int m);
        int s = 0;
        for (int i = 0; i < m - 1; i++) s += mlen[i];
        return s + d - 1;
    endfunction

    function automatic int exp_month();
        int r = m_doy;
        int m = 1;
        while (r >= mlen[m-1]) begin
            r -= mlen[m-1];
            m++;
        end
        return m;
    endfunction

    function automatic int exp_day();
        int r = m_doy;
        int m = 1;
        while (r >= mlen[m-1]) begin
            r -= mlen[m-1];
            m++;
        end
        return r + 1;
    endfunction

    task automatic model_reset();
        m_doy  = 0;
        m_year = RESET_YEAR;
        m_busy = 0;
        m_pend = 0;
        m_ny   = 0;
        m_done = 0;
        m_err  = 0;
    endtask

    task automatic model_step(input bit t, input bit lv, input int d, input int m, input int y);
        m_ny   = 0;
        m_done = 0;
        m_err  = 0;
        if (!m_busy) begin
            if (lv) begin
                c_d = d; c_m = m; c_y = y;
                m_busy = 1;
                m_pend = m_pend | t;
            end else if (t || m_pend) begin
                m_pend = 0;
                m_doy++;
                if (m_doy == 365) begin
                    m_doy  = 0;
                    m_year = (m_year + 1) % YEAR_MOD;
                    m_ny   = 1;
                end
            end
        end else begin
            if (legal(c_d, c_m)) begin
                m_doy  = doy_of(c_d, c_m);
                m_year = c_y;
                m_done = 1;
            end else begin
                m_err = 1;
            end
            m_pend = m_pend | t;
            m_busy = 0;
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("day",       32'(day_of_month), 32'(exp_day()));
        chk("month",     32'(month),        32'(exp_month()));
        chk("year",      32'(year),         32'(m_year));
        chk("newYear",   32'(new_year),     32'(m_ny));
        chk("loadDone",  32'(load_done),    32'(m_done));
        chk("loadErr",   32'(load_err),     32'(m_err));
        chk("loadReady", 32'(load_ready),   32'(!m_busy));
    endtask

    // Drive one cycle of inputs, let the edge happen, advance the model, compare.
    task automatic cycle(input bit t, input bit lv, input int d, input int m, input int y);
        tick       = t;
        load_valid = lv;
        load_day   = 6'(d);
        load_month = 4'(m);
        load_year  = YEAR_W'(y);
        @(posedge clk);
        model_step(t, lv, d, m, y);
        #1;
        compare_all();
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0);
    endtask

    int bad_d [5] = '{29, 31, 0, 15, 10};
    int bad_m [5] = '{ 2,  4, 5, 13,  0};

    initial begin
        int hold_cnt;
        int rd, rm, ry;

        rst        = 1'b1;
        tick       = 1'b0;
        load_valid = 1'b0;
        load_day   = '0;
        load_month = '0;
        load_year  = '0;
        model_reset();
        #12;
        compare_all();
        rst = 1'b0;

        // 31 ticks from 1/1 land on 1/2.
        for (int i = 0; i < 31; i++) cycle(1, 0, 0, 0, 0);
        chk("jan_roll_month", 32'(month), 32'd2);
        chk("jan_roll_day",   32'(day_of_month), 32'd1);

        // Last day of February rolls into March.
        cycle(0, 1, 28, 2, 2024);
        idle();
        chk("feb_load_done", 32'(load_done), 32'd1);
        cycle(1, 0, 0, 0, 0);
        chk("mar1_day",   32'(day_of_month), 32'd1);
        chk("mar1_month", 32'(month), 32'd3);

        // Year counter wraps to 0 with a single newYear pulse.
        cycle(0, 1, 31, 12, YEAR_MOD - 1);
        idle();
        cycle(1, 0, 0, 0, 0);
        chk("wrap_year", 32'(year), 32'd0);
        chk("wrap_ny",   32'(new_year), 32'd1);
        idle();
        chk("wrap_ny_off", 32'(new_year), 32'd0);

        // Illegal loads leave the date alone.
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, bad_d[i], bad_m[i], 1999);
            idle();
            chk("bad_load_err", 32'(load_err), 32'd1);
        end

        // Tick at accept plus tick during CHECK collapse into one advance after commit.
        cycle(0, 1, 5, 6, 2024);
        idle();
        cycle(1, 1, 30, 9, 2024);
        cycle(1, 0, 0, 0, 0);
        chk("merge_commit_day",   32'(day_of_month), 32'd30);
        chk("merge_commit_month", 32'(month), 32'd9);
        idle();
        chk("merge_adv_day",   32'(day_of_month), 32'd1);
        chk("merge_adv_month", 32'(month), 32'd10);
        idle();
        chk("merge_once_day", 32'(day_of_month), 32'd1);

        // Reset during CHECK: immediate reset values, no completion pulse afterwards.
        cycle(0, 1, 10, 10, 2030);
        load_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
        compare_all();
        idle();
        chk("rst_no_done", 32'(load_done), 32'd0);
        chk("rst_ready",   32'(load_ready), 32'd1);

        // Random ticks and held-valid loads.
        hold_cnt = 0;
        rd = 0; rm = 0; ry = 0;
        for (int n = 0; n < 3000; n++) begin
            if (hold_cnt == 0 && $urandom_range(0, 3) == 0) begin
                rm = $urandom_range(0, 13);
                rd = $urandom_range(0, 32);
                ry = $urandom_range(0, YEAR_MOD - 1);
                hold_cnt = $urandom_range(1, 3);
            end
            cycle($urandom_range(0, 2) == 0, hold_cnt > 0, rd, rm, ry);
            if (hold_cnt > 0) hold_cnt--;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
